// File: rtl/headparse_in_demux_core.sv
// Header parser / demux front end.
// Walks the first HDR_LEN bytes of each frame against a microcode ROM.
// Dynamic bytes are captured into four slots, and static bytes are verified.
// The header ends with an ok/err verdict pulse.
// A good frame's payload is passed through with one cycle of latency.
// A bad frame's payload is dropped.
// Optional feature macro: HEADPARSE_STATIC_CHECK_EN. When it is defined, static
// header bytes are compared with the ROM. When it is undefined, they are skipped
// and no comparator is built.
module headparse_in_demux_core #(
  parameter int HDR_LEN = 42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic [5:0] mc_addr,
  input  logic [8:0] microcode_in,
  output logic [7:0] dyndata_out_0,
  output logic [7:0] dyndata_out_1,
  output logic [7:0] dyndata_out_2,
  output logic [7:0] dyndata_out_3,
  output logic [3:0] dyn_wr,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  output logic       hdr_ok,
  output logic       hdr_err
);

  localparam logic [5:0] LAST_IDX = 6'(HDR_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PARSE,
    ST_PASS,
    ST_DROP
  } state_t;

  state_t     state_q;
  logic [5:0] idx_q;
  logic       mismatch_q;
  logic [7:0] dyn_q [4];
  logic [3:0] dyn_wr_q;
  logic [7:0] out_data_q;
  logic       out_valid_q;
  logic       out_last_q;
  logic       hdr_ok_q;
  logic       hdr_err_q;

  logic       is_dyn;
  logic [1:0] slot;
  logic       mm_now;
  logic       mm_total;
  logic       at_last_hdr;

  assign is_dyn      = microcode_in[8];
  assign slot        = microcode_in[1:0];
  assign at_last_hdr = (idx_q == LAST_IDX);
  assign mm_total    = mismatch_q | mm_now;

`ifdef HEADPARSE_STATIC_CHECK_EN
  // A static header byte must equal the ROM byte at the same index
  assign mm_now = !is_dyn && (in_data != microcode_in[7:0]);
`else
  // Static bytes are accepted as-is; the ROM byte value is not needed
  logic unused_static_bits;
  assign unused_static_bits = ^microcode_in[7:2];
  assign mm_now = 1'b0;
`endif

  // Header/payload FSM with all outputs registered; pulses default low each cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      mismatch_q  <= 1'b0;
      for (int i = 0; i < 4; i++) dyn_q[i] <= 8'h00;
      dyn_wr_q    <= 4'b0000;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      hdr_ok_q    <= 1'b0;
      hdr_err_q   <= 1'b0;
    end else begin
      dyn_wr_q    <= 4'b0000;
      hdr_ok_q    <= 1'b0;
      hdr_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      case (state_q)
        ST_IDLE, ST_PARSE: begin
          if (in_valid) begin
            if (is_dyn) begin
              dyn_q[slot] <= in_data;
              dyn_wr_q    <= 4'b0001 << slot;
            end
            if (at_last_hdr) begin
              // Final header byte: a frame ending here has no payload
              hdr_ok_q   <= !mm_total;
              hdr_err_q  <= mm_total;
              idx_q      <= '0;
              mismatch_q <= 1'b0;
              if (in_last)       state_q <= ST_IDLE;
              else if (mm_total) state_q <= ST_DROP;
              else               state_q <= ST_PASS;
            end else if (in_last) begin
              // Frame shorter than the header
              hdr_err_q  <= 1'b1;
              idx_q      <= '0;
              mismatch_q <= 1'b0;
              state_q    <= ST_IDLE;
            end else begin
              idx_q      <= idx_q + 6'd1;
              mismatch_q <= mm_total;
              state_q    <= ST_PARSE;
            end
          end
        end
        ST_PASS: begin
          if (in_valid) begin
            out_data_q  <= in_data;
            out_valid_q <= 1'b1;
            out_last_q  <= in_last;
            if (in_last) state_q <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (in_valid && in_last) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mc_addr       = idx_q;
  assign dyndata_out_0 = dyn_q[0];
  assign dyndata_out_1 = dyn_q[1];
  assign dyndata_out_2 = dyn_q[2];
  assign dyndata_out_3 = dyn_q[3];
  assign dyn_wr        = dyn_wr_q;
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
  assign hdr_ok        = hdr_ok_q;
  assign hdr_err       = hdr_err_q;

endmodule
